// File: rtl/afifo_rd_prefetch.sv
// afifo_rd_prefetch
// Read-side consumer stage for the async FIFO, running entirely in the read
// clock domain. Words are popped from the FIFO whenever buffer space is free
// and held in a 2-entry registered buffer (head, second). The head word is
// offered downstream on a valid/ready handshake with registered outputs.
//
// Ports:
//   rd_clk     read-domain clock
//   rd_rst     synchronous active-low reset
//   rd_data    FIFO read data, valid while rd_empty=0
//   rd_empty   FIFO empty flag
//   rd_inc     FIFO pop request (combinational from rd_empty and state only)
//   out_data   head-of-buffer word
//   out_valid  out_data holds a valid word
//   out_ready  downstream accepts the word this cycle
//   occupancy  buffered words, 0..2
//   word_cnt   completed transfers, wraps
//   stall_cnt  cycles with out_valid=1 and out_ready=0, saturates
module afifo_rd_prefetch #(
    parameter int DSIZE = 8,
    parameter int CSIZE = 16
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic [DSIZE-1:0] rd_data,
    input  logic             rd_empty,
    output logic             rd_inc,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CSIZE-1:0] word_cnt,
    output logic [CSIZE-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [DSIZE-1:0] head;
    logic [DSIZE-1:0] second;
    logic             push;
    logic             pop;

    // Saturating increment: sticks at all-ones.
    function automatic logic [CSIZE-1:0] sat_inc(input logic [CSIZE-1:0] v);
        return (&v) ? v : v + CSIZE'(1);
    endfunction

    // Pop request deliberately ignores out_ready; a FULL buffer refills one
    // cycle after it drains, which keeps the downstream ready off this path.
    assign rd_inc    = rd_rst & ~rd_empty & (state != FULL);
    assign push      = rd_inc;
    assign pop       = out_valid & out_ready;

    assign out_data  = head;
    assign occupancy = state;

    // Buffer stage: FIFO read port -> head/second registers.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst) begin
            state     <= EMPTY;
            head      <= '0;
            second    <= '0;
            out_valid <= 1'b0;
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head      <= rd_data;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head <= rd_data;
                    end else if (push) begin
                        second <= rd_data;
                        state  <= FULL;
                    end else if (pop) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head  <= second;
                        state <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase

            if (pop)
                word_cnt <= word_cnt + CSIZE'(1);
            if (out_valid && !out_ready)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_afifo_rd_prefetch.sv
// Testbench for afifo_rd_prefetch. A small FIFO model feeds both a default
// instance (CSIZE=16) and a narrow-counter instance (CSIZE=4) with identical
// inputs. Expected words are queued as they are loaded into the FIFO model; a
// monitor pops and compares whenever a transfer happens at the output.
module tb_afifo_rd_prefetch;

    logic        rd_clk = 1'b0;
    logic        rd_rst;
    logic [7:0]  rd_data;
    logic        rd_empty;
    logic        rd_inc;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  occupancy;
    logic [15:0] word_cnt;
    logic [15:0] stall_cnt;

    logic        rd_inc4;
    logic [7:0]  out_data4;
    logic        out_valid4;
    logic [1:0]  occupancy4;
    logic [3:0]  word_cnt4;
    logic [3:0]  stall_cnt4;

    // FIFO model
    logic [7:0]  fmem [0:255];
    logic [7:0]  wp = 8'd0;
    logic [7:0]  rp = 8'd0;
    int          inc_cnt = 0;

    logic [7:0]  exp_q [$];
    logic [7:0]  e;
    int          n_checks = 0;
    int          n_fail = 0;
    int          base;

    always #5 rd_clk = ~rd_clk;

    assign rd_empty = (wp == rp);
    assign rd_data  = fmem[rp];

    always @(posedge rd_clk) begin
        if (rd_inc) begin
            rp      <= rp + 8'd1;
            inc_cnt <= inc_cnt + 1;
        end
    end

    afifo_rd_prefetch #(.DSIZE(8), .CSIZE(16)) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_data(rd_data), .rd_empty(rd_empty),
        .rd_inc(rd_inc), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .occupancy(occupancy), .word_cnt(word_cnt),
        .stall_cnt(stall_cnt)
    );

    afifo_rd_prefetch #(.DSIZE(8), .CSIZE(4)) dut4 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_data(rd_data), .rd_empty(rd_empty),
        .rd_inc(rd_inc4), .out_data(out_data4), .out_valid(out_valid4),
        .out_ready(out_ready), .occupancy(occupancy4), .word_cnt(word_cnt4),
        .stall_cnt(stall_cnt4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v, input bit expect_it);
        fmem[wp] = v;
        wp = wp + 8'd1;
        if (expect_it) exp_q.push_back(v);
    endtask

    initial begin
        fork
            forever begin
                @(negedge rd_clk);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_extra_word: got 0x%0h, no word expected", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_data", out_data, e);
                        if (out_valid4) check("sb_data4", out_data4, e);
                    end
                end
            end
        join_none

        // Reset held 3 cycles with words waiting in the FIFO
        rd_rst    = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) load(8'(i), 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rd_inc", rd_inc, 0);
            check("rst_rd_inc4", rd_inc4, 0);
        end
        rd_rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("first_rd_inc", rd_inc, 1);

        // Streaming 0x01..0x10
        for (int i = 0; i < 16; i++) begin
            tick();
            check("stream_valid", out_valid, 1);
        end
        tick();
        check("stream_done_valid", out_valid, 0);
        check("stream_word_cnt", word_cnt, 16);
        check("stream_stall_cnt", stall_cnt, 0);

        // Backpressure: 0xA5, 0x5A held for 10 stall cycles
        out_ready = 1'b0;
        load(8'hA5, 1'b1);
        load(8'h5A, 1'b1);
        tick();
        for (int k = 2; k <= 10; k++) begin
            tick();
            check("bp_occupancy", occupancy, 2);
            check("bp_rd_inc", rd_inc, 0);
            check("bp_out_data", out_data, 8'hA5);
        end
        check("bp_occupancy4", occupancy4, 2);
        tick();
        check("bp_stall_cnt", stall_cnt, 10);
        out_ready = 1'b1;
        repeat (3) tick();
        check("bp_word_cnt", word_cnt, 18);

        // Empty boundary: a single word then empty
        base = inc_cnt;
        load(8'h3C, 1'b1);
        repeat (6) tick();
        check("eb_rd_inc_pulses", inc_cnt - base, 1);
        check("eb_word_cnt", word_cnt, 19);
        check("eb_occupancy", occupancy, 0);
        check("eb_out_valid", out_valid, 0);

        // Reset while holding two words
        out_ready = 1'b0;
        load(8'h11, 1'b0);
        load(8'h22, 1'b0);
        repeat (3) tick();
        check("mr_occupancy_full", occupancy, 2);
        rd_rst = 1'b0;
        load(8'h33, 1'b1);
        #1;
        check("mr_rd_inc_in_reset", rd_inc, 0);
        tick();
        rd_rst = 1'b1;
        check("mr_out_valid", out_valid, 0);
        check("mr_out_data", out_data, 0);
        check("mr_word_cnt", word_cnt, 0);
        check("mr_word_cnt4", word_cnt4, 0);
        check("mr_occupancy", occupancy, 0);
        out_ready = 1'b1;
        repeat (3) tick();
        check("mr_word_cnt_after", word_cnt, 1);

        // Counter limits on the CSIZE=4 instance
        for (int i = 0; i < 16; i++) load(8'(8'h40 + i), 1'b1);
        repeat (20) tick();
        check("cl_word_cnt", word_cnt, 17);
        check("cl_word_cnt4_wrap", word_cnt4, 1);
        out_ready = 1'b0;
        load(8'h77, 1'b1);
        repeat (22) tick();
        check("cl_stall_cnt", stall_cnt, 21);
        check("cl_stall_cnt4_sat", stall_cnt4, 15);
        repeat (3) tick();
        check("cl_stall_cnt4_held", stall_cnt4, 15);
        check("cl_stall_cnt_more", stall_cnt, 24);
        out_ready = 1'b1;
        repeat (3) tick();
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/afifo_rd_prefetch.md
# afifo_rd_prefetch

Read-side consumer stage for the async FIFO, in the read clock domain. Pops words from the FIFO read port whenever space is free and holds them in a 2-entry registered buffer. Presents the words downstream on a valid/ready handshake with fully registered outputs. Keeps a delivered-word counter and a backpressure stall counter for debug and coverage.

## Interface
Parameters:
- DSIZE, 8, data width; must match the FIFO's DSIZE.
- CSIZE, 16, width of word_cnt and stall_cnt.

Ports:
- rd_clk  input  1  read-domain clock, the only clock.
- rd_rst  input  1  synchronous, active-low reset; sampled on the rd_clk rising edge.
- rd_data  input  DSIZE  FIFO read data; valid combinationally whenever rd_empty=0.
- rd_empty  input  1  FIFO empty flag.
- rd_inc  output  1  FIFO pop request; the FIFO advances on the rd_clk edge where rd_inc=1.
- out_data  output  DSIZE  head-of-buffer word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- occupancy  output  2  buffered words, 0..2.
- word_cnt  output  CSIZE  count of completed transfers (out_valid & out_ready); wraps mod 2^CSIZE.
- stall_cnt  output  CSIZE  count of cycles with out_valid=1 and out_ready=0; saturates at all-ones.

## Operation
- Storage: two DSIZE slots, head (drives out_data) and second, plus a registered state.
- push = rd_inc. pop = out_valid & out_ready.
- rd_inc = rd_rst & ~rd_empty & (state != FULL). It is combinational from rd_empty and state only. There is no path from out_ready to rd_inc.
- State machine, with occupancy equal to the state encoding:
  - EMPTY (0):
    - push: head<=rd_data, go to ONE.
    - Otherwise stay in EMPTY.
    - pop cannot occur in EMPTY.
  - ONE (1):
    - push & pop: head<=rd_data, stay in ONE.
    - push only: second<=rd_data, go to FULL.
    - pop only: go to EMPTY.
    - Neither: hold.
  - FULL (2):
    - No push.
    - pop: head<=second, go to ONE.
    - No pop: hold.
- out_valid = (state != EMPTY). It is registered, derived from the state register.
- Order is preserved: words leave in FIFO pop order with none lost or duplicated.
- Hold rule: while out_valid=1 and out_ready=0, out_data and out_valid stay stable until a pop.
- out_ready while out_valid=0 has no effect.
- word_cnt increments by 1 on each pop and wraps from all-ones to 0.
- stall_cnt increments on each out_valid & ~out_ready cycle and sticks at 2^CSIZE-1.
- Reset (rd_rst=0 at an edge):
  - state<=EMPTY, head<=0, second<=0, word_cnt<=0, stall_cnt<=0.
  - Outputs in the following cycle: out_valid=0, out_data=0, occupancy=0, rd_inc=0 (forced low while rd_rst=0).
- Reset mid-operation discards buffered words. No pop is issued during the reset cycle.
- An empty FIFO with the buffer in EMPTY or ONE simply stops popping. No underflow is possible because rd_inc requires rd_empty=0.

## Timing
- Latency: rd_empty falls in cycle N with state EMPTY, so rd_inc=1 in cycle N. out_valid=1 and out_data equal to that word from cycle N+1.
- Throughput is 1 word/cycle sustained in state ONE with out_ready=1 and rd_empty=0.
- With FULL and a pop in cycle N, rd_inc may reassert in cycle N+1. This one-bubble refill is required behaviour: it keeps out_ready off the rd_inc path.
- All outputs except rd_inc are registered.
- Counters update on the same edge as the event they count and are visible the next cycle.

## Test plan
- Reset: hold rd_rst=0 for 3 cycles with rd_empty=0.
  - rd_inc=0 throughout.
  - After release: out_valid=0, occupancy=0, word_cnt=0, stall_cnt=0 until the first pop.
- Streaming: FIFO supplies 0x01..0x10 with out_ready=1.
  - out_data shows 0x01..0x10 on consecutive cycles starting 1 cycle after the first rd_inc.
  - word_cnt=16; stall_cnt=0.
- Backpressure: load 0xA5, 0x5A with out_ready=0 for 10 cycles.
  - occupancy=2, rd_inc=0, out_data=0xA5 stable.
  - stall_cnt=10.
  - Release: 0xA5 then 0x5A, in order.
- Empty boundary: FIFO holds 1 word (0x3C), then rd_empty=1.
  - Exactly one rd_inc pulse; 0x3C delivered once; occupancy returns to 0.
  - No further rd_inc.
- Reset mid-operation: occupancy=2 holding 0x11, 0x22; assert rd_rst for 1 cycle.
  - out_valid=0, out_data=0, word_cnt=0.
  - Next FIFO word 0x33 is the first one delivered.
- Counter limits with CSIZE=4:
  - 17 transfers give word_cnt=1.
  - 20 stall cycles give stall_cnt=15, held.
